hand_display_scheduler: RTL and testbench

Frame-synchronous update scheduler for the hand-location overlay. It accepts hand-coordinate samples from the Kinect tracking pipeline through a valid/ready handshake and holds one sample pending. At each vertical-sync frame boundary it commits that sample to scaled, clamped display registers, so blob positions never change mid-frame. Per-hand staleness counters hide a blob that has not been refreshed for a configurable number of frames. It sits between the tracker and the hand overlay renderer and drives that renderer's x/y/z inputs.

---
 rtl/hand_display_scheduler_if.sv | 22 ++
 rtl/hand_display_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_hand_display_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hand_display_scheduler_if.sv
// Tracker-to-scheduler sample handshake: valid/ready plus per-hand flags and raw coordinates.
interface hand_display_scheduler_if;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_hand;
  logic [15:0] s_x1;
  logic [15:0] s_y1;
  logic [15:0] s_z1;
  logic [15:0] s_x2;
  logic [15:0] s_y2;
  logic [15:0] s_z2;

  modport master (
    output s_valid, s_hand, s_x1, s_y1, s_z1, s_x2, s_y2, s_z2,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_hand, s_x1, s_y1, s_z1, s_x2, s_y2, s_z2,
    output s_ready
  );
endinterface

// File: rtl/hand_display_scheduler.sv
// Frame-synchronous hand overlay scheduler: one pending sample is committed, scaled and clamped at each vsync fall.
// Optional macro HAND_SMOOTH_EN averages a visible hand's new x/y with its previous display position.
module hand_display_scheduler #(
  parameter int unsigned STALE_FRAMES = 30,
  parameter int unsigned DISP_X_MAX   = 960,
  parameter int unsigned DISP_Y_MAX   = 704
) (
  input  logic                    vclock,
  input  logic                    reset_n,
  input  logic                    vsync,
  hand_display_scheduler_if.slave trk,
  output logic [15:0]             x1_disp,
  output logic [15:0]             y1_disp,
  output logic [15:0]             z1_disp,
  output logic [15:0]             x2_disp,
  output logic [15:0]             y2_disp,
  output logic [15:0]             z2_disp,
  output logic                    hand1_visible,
  output logic                    hand2_visible,
  output logic                    frame_commit
);

  localparam logic [7:0]  STALE_MAX = 8'(STALE_FRAMES);
  localparam logic [17:0] X_LIM     = 18'(DISP_X_MAX);
  localparam logic [17:0] Y_LIM     = 18'(DISP_Y_MAX);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // Halve, triple and clamp in 18 bits so the clamp sees the full product.
  function automatic logic [15:0] scale_clamp(input logic [15:0] raw, input logic [17:0] lim);
    logic [17:0] prod;
    prod = ({2'b00, raw} >> 1) * 18'd3;
    if (prod > lim) begin
      scale_clamp = lim[15:0];
    end else begin
      scale_clamp = prod[15:0];
    end
  endfunction

  function automatic logic [7:0] stale_next(input logic refresh, input logic [7:0] cur);
    if (refresh) begin
      stale_next = 8'd0;
    end else if (cur < STALE_MAX) begin
      stale_next = cur + 8'd1;
    end else begin
      stale_next = cur;
    end
  endfunction

`ifdef HAND_SMOOTH_EN
  function automatic logic [15:0] smooth_avg(input logic [15:0] old_v, input logic [15:0] new_v);
    smooth_avg = 16'((17'(old_v) + 17'(new_v)) >> 1);
  endfunction
`endif

  state_t      state_r;
  logic        vs_d1_r, vs_d2_r;
  logic        pend_full_r;
  logic [1:0]  pend_hand_r;
  logic [15:0] pend_x1_r, pend_y1_r, pend_z1_r, pend_x2_r, pend_y2_r, pend_z2_r;
  logic [15:0] x1_disp_r, y1_disp_r, z1_disp_r, x2_disp_r, y2_disp_r, z2_disp_r;
  logic [7:0]  stale1_r, stale2_r;
  logic        hand1_visible_r, hand2_visible_r, frame_commit_r;

  logic        fall_s, ready_s, take_s, refresh1_s, refresh2_s;
  logic [15:0] x1_scaled_s, y1_scaled_s, x2_scaled_s, y2_scaled_s;
  logic [15:0] x1_new_s, y1_new_s, x2_new_s, y2_new_s;
  logic [7:0]  stale1_next_s, stale2_next_s;

  // Frame-boundary detect, handshake and next-value datapath for the commit cycle.
  always_comb begin
    fall_s        = vs_d2_r & ~vs_d1_r;
    ready_s       = ~pend_full_r & (state_r == ST_IDLE);
    take_s        = trk.s_valid & ready_s;
    refresh1_s    = pend_full_r & pend_hand_r[0];
    refresh2_s    = pend_full_r & pend_hand_r[1];
    x1_scaled_s   = scale_clamp(pend_x1_r, X_LIM);
    y1_scaled_s   = scale_clamp(pend_y1_r, Y_LIM);
    x2_scaled_s   = scale_clamp(pend_x2_r, X_LIM);
    y2_scaled_s   = scale_clamp(pend_y2_r, Y_LIM);
    stale1_next_s = stale_next(refresh1_s, stale1_r);
    stale2_next_s = stale_next(refresh2_s, stale2_r);
`ifdef HAND_SMOOTH_EN
    // A hand that was hidden jumps straight to its new position instead of averaging from a stale one.
    if (hand1_visible_r) begin
      x1_new_s = smooth_avg(x1_disp_r, x1_scaled_s);
      y1_new_s = smooth_avg(y1_disp_r, y1_scaled_s);
    end else begin
      x1_new_s = x1_scaled_s;
      y1_new_s = y1_scaled_s;
    end
    if (hand2_visible_r) begin
      x2_new_s = smooth_avg(x2_disp_r, x2_scaled_s);
      y2_new_s = smooth_avg(y2_disp_r, y2_scaled_s);
    end else begin
      x2_new_s = x2_scaled_s;
      y2_new_s = y2_scaled_s;
    end
`else
    x1_new_s = x1_scaled_s;
    y1_new_s = y1_scaled_s;
    x2_new_s = x2_scaled_s;
    y2_new_s = y2_scaled_s;
`endif
  end

  // Two-flop vsync synchronizer; idles high so reset release never looks like a fall.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d1_r <= 1'b1;
      vs_d2_r <= 1'b1;
    end else begin
      vs_d1_r <= vsync;
      vs_d2_r <= vs_d1_r;
    end
  end

  // Scheduler FSM with the pending buffer, display registers and staleness tracking.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      pend_full_r     <= 1'b0;
      pend_hand_r     <= 2'b00;
      pend_x1_r       <= 16'd0;
      pend_y1_r       <= 16'd0;
      pend_z1_r       <= 16'd0;
      pend_x2_r       <= 16'd0;
      pend_y2_r       <= 16'd0;
      pend_z2_r       <= 16'd0;
      x1_disp_r       <= 16'd0;
      y1_disp_r       <= 16'd0;
      z1_disp_r       <= 16'd0;
      x2_disp_r       <= 16'd0;
      y2_disp_r       <= 16'd0;
      z2_disp_r       <= 16'd0;
      stale1_r        <= STALE_MAX;
      stale2_r        <= STALE_MAX;
      hand1_visible_r <= 1'b0;
      hand2_visible_r <= 1'b0;
      frame_commit_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_commit_r <= 1'b0;
          if (fall_s) begin
            state_r <= ST_COMMIT;
          end else begin
            state_r <= ST_IDLE;
          end
          if (take_s) begin
            pend_full_r <= 1'b1;
            pend_hand_r <= trk.s_hand;
            pend_x1_r   <= trk.s_x1;
            pend_y1_r   <= trk.s_y1;
            pend_z1_r   <= trk.s_z1;
            pend_x2_r   <= trk.s_x2;
            pend_y2_r   <= trk.s_y2;
            pend_z2_r   <= trk.s_z2;
          end
        end
        ST_COMMIT: begin
          state_r        <= ST_IDLE;
          frame_commit_r <= 1'b1;
          pend_full_r    <= 1'b0;
          if (refresh1_s) begin
            x1_disp_r <= x1_new_s;
            y1_disp_r <= y1_new_s;
            z1_disp_r <= pend_z1_r;
          end
          if (refresh2_s) begin
            x2_disp_r <= x2_new_s;
            y2_disp_r <= y2_new_s;
            z2_disp_r <= pend_z2_r;
          end
          stale1_r        <= stale1_next_s;
          stale2_r        <= stale2_next_s;
          hand1_visible_r <= (stale1_next_s < STALE_MAX);
          hand2_visible_r <= (stale2_next_s < STALE_MAX);
        end
        default: begin
          state_r        <= ST_IDLE;
          frame_commit_r <= 1'b0;
          pend_full_r    <= 1'b0;
        end
      endcase
    end
  end

  assign trk.s_ready   = ready_s;
  assign x1_disp       = x1_disp_r;
  assign y1_disp       = y1_disp_r;
  assign z1_disp       = z1_disp_r;
  assign x2_disp       = x2_disp_r;
  assign y2_disp       = y2_disp_r;
  assign z2_disp       = z2_disp_r;
  assign hand1_visible = hand1_visible_r;
  assign hand2_visible = hand2_visible_r;
  assign frame_commit  = frame_commit_r;

endmodule

// File: tb/tb_hand_display_scheduler.sv
// Self-checking bench for hand_display_scheduler: directed steps plus randomized frames against a behavioural model.
module tb_hand_display_scheduler;

  localparam int STALE = 30;
  localparam int XMAX  = 960;
  localparam int YMAX  = 704;

  logic        vclock;
  logic        reset_n;
  logic        vsync;
  logic [15:0] x1_disp, y1_disp, z1_disp, x2_disp, y2_disp, z2_disp;
  logic        hand1_visible, hand2_visible, frame_commit;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_disp [2][3];
  int          m_stale [2];
  bit          m_pend_full;
  logic [1:0]  m_pend_hand;
  logic [15:0] m_pend [6];

  hand_display_scheduler_if bus ();

  hand_display_scheduler dut (
    .vclock        (vclock),
    .reset_n       (reset_n),
    .vsync         (vsync),
    .trk           (bus.slave),
    .x1_disp       (x1_disp),
    .y1_disp       (y1_disp),
    .z1_disp       (z1_disp),
    .x2_disp       (x2_disp),
    .y2_disp       (y2_disp),
    .z2_disp       (z2_disp),
    .hand1_visible (hand1_visible),
    .hand2_visible (hand2_visible),
    .frame_commit  (frame_commit)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int scale(input int raw, input int lim);
    int v;
    v = (raw / 2) * 3;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < 3; c++) m_disp[h][c] = 0;
      m_stale[h] = STALE;
    end
    m_pend_full = 1'b0;
  endtask

  task automatic model_accept(input logic [1:0] h, input logic [15:0] v [6]);
    m_pend_full = 1'b1;
    m_pend_hand = h;
    for (int i = 0; i < 6; i++) m_pend[i] = v[i];
  endtask

  task automatic model_commit();
    int sc;
    for (int h = 0; h < 2; h++) begin
      if (m_pend_full && m_pend_hand[h]) begin
        for (int c = 0; c < 2; c++) begin
          sc = scale(int'(m_pend[h*3+c]), (c == 0) ? XMAX : YMAX);
`ifdef HAND_SMOOTH_EN
          if (m_stale[h] < STALE) sc = (m_disp[h][c] + sc) / 2;
`endif
          m_disp[h][c] = sc;
        end
        m_disp[h][2] = int'(m_pend[h*3+2]);
        m_stale[h]   = 0;
      end else if (m_stale[h] < STALE) begin
        m_stale[h]++;
      end
    end
    m_pend_full = 1'b0;
  endtask

  task automatic check_all();
    chk("x1_disp", x1_disp, m_disp[0][0]);
    chk("y1_disp", y1_disp, m_disp[0][1]);
    chk("z1_disp", z1_disp, m_disp[0][2]);
    chk("x2_disp", x2_disp, m_disp[1][0]);
    chk("y2_disp", y2_disp, m_disp[1][1]);
    chk("z2_disp", z2_disp, m_disp[1][2]);
    chk("hand1_visible", hand1_visible, (m_stale[0] < STALE) ? 1 : 0);
    chk("hand2_visible", hand2_visible, (m_stale[1] < STALE) ? 1 : 0);
  endtask

  task automatic drive(input logic [1:0] h, input logic [15:0] v [6]);
    bus.s_valid = 1'b1;
    bus.s_hand  = h;
    bus.s_x1 = v[0]; bus.s_y1 = v[1]; bus.s_z1 = v[2];
    bus.s_x2 = v[3]; bus.s_y2 = v[4]; bus.s_z2 = v[5];
  endtask

  function automatic logic [15:0] rand_coord();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(630, 650));
      2:       return 16'($urandom_range(460, 480));
      default: return 16'($urandom_range(0, 2000));
    endcase
  endfunction

  // Present a sample and wait (bounded) for the handshake to complete.
  task automatic send(input logic [1:0] h, input logic [15:0] v [6]);
    int waited;
    waited = 0;
    @(negedge vclock);
    drive(h, v);
    while (bus.s_ready !== 1'b1 && waited < 8) begin
      @(negedge vclock);
      waited++;
    end
    chk("send_ready", bus.s_ready, 1);
    if (bus.s_ready === 1'b1) begin
      @(posedge vclock);
      #1;
      model_accept(h, v);
    end
    bus.s_valid = 1'b0;
  endtask

  // One vsync low pulse; optionally offers a sample in the cycle before the FSM enters commit.
  task automatic do_frame(input bit late);
    logic [1:0]  lh;
    logic [15:0] lv [6];
    lh = 2'b00;
    for (int i = 0; i < 6; i++) lv[i] = 16'd0;
    @(negedge vclock);
    vsync = 1'b0;
    @(posedge vclock);
    @(negedge vclock);
    if (late) begin
      lh = 2'($urandom_range(0, 3));
      for (int i = 0; i < 6; i++) lv[i] = rand_coord();
      drive(lh, lv);
      chk("s_ready_before_e1", bus.s_ready, 1);
    end
    @(posedge vclock);
    #1;
    bus.s_valid = 1'b0;
    if (late) model_accept(lh, lv);
    chk("s_ready_in_commit", bus.s_ready, 0);
    chk("frame_commit_e1", frame_commit, 0);
    model_commit();
    @(posedge vclock);
    #1;
    chk("frame_commit_e2", frame_commit, 1);
    check_all();
    chk("s_ready_after_commit", bus.s_ready, 1);
    @(posedge vclock);
    #1;
    chk("frame_commit_single", frame_commit, 0);
    @(negedge vclock);
    vsync = 1'b1;
    repeat (3) @(posedge vclock);
    #1;
    chk("frame_commit_idle", frame_commit, 0);
  endtask

  initial begin
    logic [15:0] v [6];
    logic [1:0]  h;
    reset_n     = 1'b0;
    vsync       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_hand  = 2'b00;
    bus.s_x1 = 16'd0; bus.s_y1 = 16'd0; bus.s_z1 = 16'd0;
    bus.s_x2 = 16'd0; bus.s_y2 = 16'd0; bus.s_z2 = 16'd0;
    model_reset();
    repeat (3) @(posedge vclock);
    @(negedge vclock);
    reset_n = 1'b1;
    #1;

    // Reset state and an empty commit
    check_all();
    chk("reset_s_ready", bus.s_ready, 1);
    chk("reset_frame_commit", frame_commit, 0);
    do_frame(1'b0);
    chk("empty_hand1_visible", hand1_visible, 0);

    // Basic scaling
    v = '{16'd100, 16'd200, 16'd900, 16'd7, 16'd8, 16'd9};
    send(2'b01, v);
    do_frame(1'b0);
    chk("basic_x1", x1_disp, 150);
    chk("basic_y1", y1_disp, 300);
    chk("basic_z1", z1_disp, 900);
    chk("basic_vis1", hand1_visible, 1);
    chk("basic_vis2", hand2_visible, 0);

    // Second sample on a visible hand (averaged when smoothing is built in)
    v = '{16'd300, 16'd200, 16'd901, 16'd0, 16'd0, 16'd0};
    send(2'b01, v);
    do_frame(1'b0);
`ifdef HAND_SMOOTH_EN
    chk("second_x1", x1_disp, 300);
`else
    chk("second_x1", x1_disp, 450);
`endif

    // Clamp boundaries
    v = '{16'd1000, 16'd600, 16'd5, 16'd641, 16'd469, 16'd6};
    send(2'b11, v);
    do_frame(1'b0);
`ifndef HAND_SMOOTH_EN
    chk("clamp_x1", x1_disp, 960);
    chk("clamp_y1", y1_disp, 704);
`endif
    chk("edge_x2", x2_disp, 960);
    chk("edge_y2", y2_disp, 702);

    // Staleness: hand 1 refreshed, then 30 frames with no samples
    v = '{16'd400, 16'd400, 16'd44, 16'd0, 16'd0, 16'd0};
    send(2'b01, v);
    do_frame(1'b0);
    for (int i = 1; i <= STALE; i++) begin
      do_frame(1'b0);
      chk("stale_vis1", hand1_visible, (i < STALE) ? 1 : 0);
    end

    // A second sample stalls while one is pending; the first one commits
    v = '{16'd500, 16'd100, 16'd11, 16'd0, 16'd0, 16'd0};
    send(2'b01, v);
    @(negedge vclock);
    v = '{16'd20, 16'd20, 16'd22, 16'd0, 16'd0, 16'd0};
    drive(2'b01, v);
    for (int i = 0; i < 3; i++) begin
      chk("stall_s_ready", bus.s_ready, 0);
      @(negedge vclock);
    end
    bus.s_valid = 1'b0;
    do_frame(1'b0);
    chk("stall_x1", x1_disp, 750);
    chk("stall_z1", z1_disp, 11);

    // Sample offered right before commit lands in that commit
    do_frame(1'b1);

    // Reset asserted mid-commit with a sample pending
    v = '{16'd600, 16'd300, 16'd33, 16'd0, 16'd0, 16'd0};
    send(2'b01, v);
    @(negedge vclock);
    vsync = 1'b0;
    @(posedge vclock);
    @(posedge vclock);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_frame_commit", frame_commit, 0);
    vsync = 1'b1;
    @(negedge vclock);
    @(negedge vclock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge vclock);
      #1;
      chk("rst_no_commit", frame_commit, 0);
    end
    check_all();

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      bit late;
      late = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        h = 2'($urandom_range(0, 3));
        for (int i = 0; i < 6; i++) v[i] = rand_coord();
        send(h, v);
      end else begin
        late = ($urandom_range(0, 1) == 1);
      end
      do_frame(late);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
